hsci_miso_word_aligner: RTL

// - Sits directly downstream of the HSCI PHY, one instance per MISO lane, in the hsci_pclk domain.
// - Takes the 8-bit deserialized MISO bytes, which are in arbitrary bit phase after PHY reset.
// - Finds the bit offset at which the training byte SYNC_BYTE appears and confirms it LOCK_COUNT times.
// - Then emits byte-aligned MISO data to the HSCI link layer, with a lock flag and a search-timeout flag.

---
 rtl/hsci_miso_word_aligner.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/hsci_miso_word_aligner.sv
// Aligns the arbitrary-phase MISO byte stream from the HSCI PHY to the training byte.
// It searches for the bit offset, confirms it, and then emits byte-aligned data.
module hsci_miso_word_aligner #(
  parameter logic [7:0]  SYNC_BYTE      = 8'h1E,
  parameter int unsigned LOCK_COUNT     = 4,
  parameter int unsigned SEARCH_TIMEOUT = 1024
) (
  input  logic       hsci_pclk,
  input  logic       hsci_rst,
  input  logic [7:0] miso_data_in,
  input  logic       miso_valid_in,
  input  logic       align_restart,
  output logic [7:0] miso_data_out,
  output logic       miso_valid_out,
  output logic       aligned,
  output logic [2:0] align_offset,
  output logic       search_timeout
);

  localparam int unsigned   CW      = $clog2(SEARCH_TIMEOUT);
  localparam logic [CW-1:0] SC_LAST = CW'(SEARCH_TIMEOUT - 1);
  localparam logic [3:0]    LC      = 4'(LOCK_COUNT);

  function automatic logic [7:0] f_rotl(input logic [7:0] b, input int n);
    return 8'({b, b} >> (8 - n));
  endfunction

  // A byte with a repeated rotation would make the offset ambiguous.
  function automatic logic f_rot_distinct(input logic [7:0] b);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        if (f_rotl(b, i) == f_rotl(b, j)) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  if (!f_rot_distinct(SYNC_BYTE)) begin : g_bad_sync
    $error("SYNC_BYTE has repeated bit rotations");
  end
  if (LOCK_COUNT < 1 || LOCK_COUNT > 15) begin : g_bad_lock
    $error("LOCK_COUNT must be in 1..15");
  end
  if (SEARCH_TIMEOUT < 2) begin : g_bad_timeout
    $error("SEARCH_TIMEOUT must be at least 2");
  end

  typedef enum logic [1:0] {
    S_SEARCH = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_data_q, w_data_q_nxt;
  logic          r_have_prev, w_have_prev_nxt;
  logic [3:0]    r_match_cnt, w_match_cnt_nxt;
  logic [CW-1:0] r_search_cnt, w_search_cnt_nxt;
  logic [7:0]    r_data_out, w_data_out_nxt;
  logic          r_valid_out, w_valid_out_nxt;
  logic          r_aligned;
  logic [2:0]    r_offset, w_offset_nxt;
  logic          r_timeout, w_timeout_nxt;

  logic [15:0]   w_win;
  logic [7:0]    w_match;
  logic          w_hit;
  logic [2:0]    w_hit_k;
  logic [7:0]    w_sel;
  logic [3:0]    w_match_inc;

  assign w_win       = {r_data_q, miso_data_in};
  assign w_sel       = 8'(w_win >> (4'd8 - {1'b0, r_offset}));
  assign w_match_inc = r_match_cnt + 4'd1;

  for (genvar k = 0; k < 8; k++) begin : g_slice
    assign w_match[k] = (w_win[15-k -: 8] == SYNC_BYTE);
  end

  // Lowest matching offset wins.
  always_comb begin
    w_hit   = |w_match;
    w_hit_k = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      w_hit_k = w_match[k] ? 3'(k) : w_hit_k;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_data_q_nxt     = r_data_q;
    w_have_prev_nxt  = r_have_prev;
    w_match_cnt_nxt  = r_match_cnt;
    w_search_cnt_nxt = r_search_cnt;
    w_data_out_nxt   = r_data_out;
    w_valid_out_nxt  = 1'b0;
    w_offset_nxt     = r_offset;
    w_timeout_nxt    = r_timeout;
    if (align_restart) begin
      w_state_nxt      = S_SEARCH;
      w_have_prev_nxt  = 1'b0;
      w_match_cnt_nxt  = 4'd0;
      w_search_cnt_nxt = '0;
      w_timeout_nxt    = 1'b0;
    end else if (miso_valid_in) begin
      w_data_q_nxt    = miso_data_in;
      w_have_prev_nxt = 1'b1;
      if (r_have_prev) begin
        case (r_state)
          S_SEARCH: begin
            if (w_hit) begin
              w_offset_nxt     = w_hit_k;
              w_match_cnt_nxt  = 4'd1;
              w_search_cnt_nxt = '0;
              w_state_nxt      = (LC == 4'd1) ? S_LOCKED : S_VERIFY;
            end else if (r_search_cnt == SC_LAST) begin
              w_timeout_nxt    = 1'b1;
              w_search_cnt_nxt = '0;
            end else begin
              w_search_cnt_nxt = r_search_cnt + 1'b1;
            end
          end
          S_VERIFY: begin
            if (w_sel == SYNC_BYTE) begin
              w_match_cnt_nxt = w_match_inc;
              w_state_nxt     = (w_match_inc == LC) ? S_LOCKED : S_VERIFY;
            end else begin
              w_match_cnt_nxt = 4'd0;
              w_state_nxt     = S_SEARCH;
            end
          end
          S_LOCKED: begin
            w_data_out_nxt  = w_sel;
            w_valid_out_nxt = 1'b1;
          end
          default: begin
            w_state_nxt = S_SEARCH;
          end
        endcase
      end else begin
        w_state_nxt = r_state;
      end
    end else begin
      w_valid_out_nxt = 1'b0;
    end
  end

  always_ff @(posedge hsci_pclk) begin
    if (hsci_rst) begin
      r_state      <= S_SEARCH;
      r_data_q     <= 8'd0;
      r_have_prev  <= 1'b0;
      r_match_cnt  <= 4'd0;
      r_search_cnt <= '0;
      r_data_out   <= 8'd0;
      r_valid_out  <= 1'b0;
      r_aligned    <= 1'b0;
      r_offset     <= 3'd0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_data_q     <= w_data_q_nxt;
      r_have_prev  <= w_have_prev_nxt;
      r_match_cnt  <= w_match_cnt_nxt;
      r_search_cnt <= w_search_cnt_nxt;
      r_data_out   <= w_data_out_nxt;
      r_valid_out  <= w_valid_out_nxt;
      r_aligned    <= (w_state_nxt == S_LOCKED);
      r_offset     <= w_offset_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  assign miso_data_out  = r_data_out;
  assign miso_valid_out = r_valid_out;
  assign aligned        = r_aligned;
  assign align_offset   = r_offset;
  assign search_timeout = r_timeout;

endmodule
